fetch_pc_unit: RTL and testbench

- Instruction-fetch front end that sits directly upstream of the branch predictor and feeds the decode stage.
- Owns the architectural fetch PC and presents it to the predictor each cycle. Issues instruction-memory requests and advances the PC to the predicted next PC.
- Buffers returned instructions, with their PC and prediction metadata, in a small FIFO toward decode.
- Applies execute-stage redirects on a mispredict or a taken branch.

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/fetch_fifo.sv | 74 +++++++
 rtl/fetch_pc_unit.sv | 135 +++++++++++++
 tb/tb_fetch_pc_unit.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction-fetch front end.
package fetch_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   // One fetched instruction with the prediction that produced its successor
   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        pred_taken;
      logic [31:0] pred_pc;
   } fetch_entry_t;

   // Ceiling log2, used to size FIFO pointers
   function automatic int unsigned log2_ceil(input int unsigned n);
      int unsigned r;
      r = 32'd0;
      for (int unsigned i = 0; i < 32'd32; i++) begin
         if (((n - 32'd1) >> i) != 32'd0) r = i + 32'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Registered fetch buffer toward decode; flush empties it in one cycle.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       flush,
   input  fetch_entry_t               push_data,
   output fetch_entry_t               head,
   output logic [log2_ceil(DEPTH):0]  count,
   output logic                       empty,
   output logic                       full
);

   localparam int unsigned PTR_W = log2_ceil(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   fetch_entry_t     mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CNT_W'(DEPTH));
   assign count   = count_q;
   assign head    = mem_q[rd_ptr_q];
   // A push into a full buffer is only legal alongside a pop
   assign do_push = push & (~full | pop);
   assign do_pop  = pop & ~empty;

   // Pointer and occupancy update; pointers wrap naturally
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   // Pointer/count registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (do_push && !flush) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch PC owner: issues imem requests, tracks the single outstanding
// response and buffers returned instructions toward decode.
module fetch_pc_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] bp_pc_fetch,
   input  logic [31:0] bp_pred_pc,
   input  logic        bp_pred_taken,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        dec_valid,
   input  logic        dec_ready,
   output logic [31:0] dec_instr,
   output logic [31:0] dec_pc,
   output logic        dec_pred_taken,
   output logic [31:0] dec_pred_pc
);

   localparam int unsigned CNT_W = log2_ceil(FIFO_DEPTH) + 1;
   localparam int unsigned OCC_W = CNT_W + 1;

   logic [31:0]      pc_q, pc_d;
   logic             inflight_q, inflight_d;
   logic             kill_q, kill_d;
   logic [31:0]      meta_pc_q, meta_pc_d;
   logic             meta_taken_q, meta_taken_d;
   logic [31:0]      meta_pred_pc_q, meta_pred_pc_d;

   logic [CNT_W-1:0] fifo_count;
   logic             fifo_empty, fifo_full;
   logic             fifo_push, pop, accept;
   logic [OCC_W-1:0] occ;
   fetch_entry_t     push_entry, head;
   logic             unused_bits;

   assign bp_pc_fetch = pc_q;
   assign imem_addr   = pc_q;
   // Address LSBs are forced to zero; full is implied by the issue guard
   assign unused_bits = ^{redirect_pc[1:0], bp_pred_pc[1:0], fifo_full};

   // Issue guard and response acceptance
   always_comb begin
      pop       = ~fifo_empty & dec_ready;
      occ       = OCC_W'(fifo_count) + OCC_W'(inflight_q) - OCC_W'(pop);
      imem_req  = ~rst & ~redirect_valid & (occ < OCC_W'(FIFO_DEPTH));
      accept    = imem_req & imem_gnt;
      fifo_push = imem_rvalid & inflight_q & ~kill_q & ~redirect_valid;
      push_entry = '{instr: imem_rdata, pc: meta_pc_q,
                     pred_taken: meta_taken_q, pred_pc: meta_pred_pc_q};
   end

   // PC, outstanding-request and metadata next state; redirect wins
   always_comb begin
      pc_d           = pc_q;
      inflight_d     = inflight_q;
      kill_d         = 1'b0;
      meta_pc_d      = meta_pc_q;
      meta_taken_d   = meta_taken_q;
      meta_pred_pc_d = meta_pred_pc_q;
      if (redirect_valid) begin
         pc_d           = {redirect_pc[31:2], 2'b00};
         inflight_d     = 1'b0;
         kill_d         = inflight_q & ~imem_rvalid;
         meta_pc_d      = '0;
         meta_taken_d   = 1'b0;
         meta_pred_pc_d = '0;
      end else if (accept) begin
         pc_d           = {bp_pred_pc[31:2], 2'b00};
         inflight_d     = 1'b1;
         meta_pc_d      = pc_q;
         meta_taken_d   = bp_pred_taken;
         meta_pred_pc_d = {bp_pred_pc[31:2], 2'b00};
      end else if (imem_rvalid) begin
         inflight_d     = 1'b0;
      end
   end

   // State registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q           <= {RESET_PC[31:2], 2'b00};
         inflight_q     <= 1'b0;
         kill_q         <= 1'b0;
         meta_pc_q      <= '0;
         meta_taken_q   <= 1'b0;
         meta_pred_pc_q <= '0;
      end else begin
         pc_q           <= pc_d;
         inflight_q     <= inflight_d;
         kill_q         <= kill_d;
         meta_pc_q      <= meta_pc_d;
         meta_taken_q   <= meta_taken_d;
         meta_pred_pc_q <= meta_pred_pc_d;
      end
   end

   fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push),
      .pop       (pop),
      .flush     (redirect_valid),
      .push_data (push_entry),
      .head      (head),
      .count     (fifo_count),
      .empty     (fifo_empty),
      .full      (fifo_full)
   );

   // Decode-facing view of the buffer head; data reads zero when empty
   always_comb begin
      dec_valid      = ~fifo_empty;
      dec_instr      = '0;
      dec_pc         = '0;
      dec_pred_taken = 1'b0;
      dec_pred_pc    = '0;
      if (!fifo_empty) begin
         dec_instr      = head.instr;
         dec_pc         = head.pc;
         dec_pred_taken = head.pred_taken;
         dec_pred_pc    = head.pred_pc;
      end
   end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench for fetch_pc_unit: accepted fetches queue expected
// decode entries, a monitor compares them as decode consumes the head.
module tb_fetch_pc_unit;
   import fetch_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] bp_pc_fetch, bp_pred_pc;
   logic        bp_pred_taken;
   logic        imem_req, imem_gnt;
   logic [31:0] imem_addr;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata  = 32'h0;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        dec_valid, dec_ready, dec_pred_taken;
   logic [31:0] dec_instr, dec_pc, dec_pred_pc;

   int n_pass  = 0;
   int n_total = 0;

   fetch_entry_t exp_q[$];
   logic [31:0]  exp_pc = 32'h0;
   logic         s_acc = 1'b0, s_redir = 1'b0;
   logic [31:0]  s_rpc = 32'h0;

   always #5 clk = ~clk;

   fetch_pc_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
      .clk(clk), .rst(rst),
      .bp_pc_fetch(bp_pc_fetch), .bp_pred_pc(bp_pred_pc), .bp_pred_taken(bp_pred_taken),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_instr(dec_instr),
      .dec_pc(dec_pc), .dec_pred_taken(dec_pred_taken), .dec_pred_pc(dec_pred_pc)
   );

   function automatic logic taken_of(input logic [31:0] a);
      return a == 32'h8;
   endfunction
   function automatic logic [31:0] pred_of(input logic [31:0] a);
      return taken_of(a) ? 32'h40 : a + 32'd4;
   endfunction
   function automatic logic [31:0] rdata_of(input logic [31:0] a);
      return a ^ 32'h1357_9BDF;
   endfunction

   // Predictor: pc+4, except a taken branch at 0x8 to 0x40
   assign bp_pred_taken = taken_of(bp_pc_fetch);
   assign bp_pred_pc    = pred_of(bp_pc_fetch);

   // Instruction memory: responds exactly one cycle after accept
   always @(posedge clk) begin
      imem_rvalid <= imem_req & imem_gnt;
      imem_rdata  <= (imem_req & imem_gnt) ? rdata_of(imem_addr) : 32'h0;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Sample issue side mid-cycle and check the fetch address
   always @(negedge clk) begin
      s_acc   = imem_req & imem_gnt;
      s_redir = redirect_valid;
      s_rpc   = redirect_pc;
      if (s_acc === 1'b1) chk("issue_addr", imem_addr, exp_pc);
      if (dut.u_fifo.push === 1'b1 && dut.u_fifo.full === 1'b1)
         chk("push_while_full_pop", 32'(dut.u_fifo.pop), 32'd1);
   end

   // Producer: apply the sampled cycle to the expected stream
   always @(posedge clk or posedge rst) begin
      fetch_entry_t e;
      if (rst) begin
         exp_q.delete();
         exp_pc = 32'h0;
      end else if (s_redir) begin
         exp_q.delete();
         exp_pc = {s_rpc[31:2], 2'b00};
      end else if (s_acc) begin
         e = '{instr: rdata_of(exp_pc), pc: exp_pc,
               pred_taken: taken_of(exp_pc), pred_pc: pred_of(exp_pc)};
         exp_q.push_back(e);
         exp_pc = pred_of(exp_pc);
      end
   end

   // Monitor: every consumed head must match the oldest expected entry
   always @(negedge clk) begin
      fetch_entry_t e;
      if (dec_valid === 1'b1 && dec_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL dec_unexpected: got pc %h expected no entry at %0t", dec_pc, $time);
         end else begin
            e = exp_q.pop_front();
            chk("dec_pc", dec_pc, e.pc);
            chk("dec_instr", dec_instr, e.instr);
            chk("dec_pred_taken", 32'(dec_pred_taken), 32'(e.pred_taken));
            chk("dec_pred_pc", dec_pred_pc, e.pred_pc);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic got;
      rst = 1'b1; imem_gnt = 1'b1; dec_ready = 1'b1;
      redirect_valid = 1'b0; redirect_pc = 32'h0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_imem_req", 32'(imem_req), 32'd0);
      chk("rst_dec_valid", 32'(dec_valid), 32'd0);
      chk("rst_pc_fetch", bp_pc_fetch, 32'h0);
      chk("rst_dec_instr", dec_instr, 32'h0);
      chk("rst_dec_pc", dec_pc, 32'h0);

      // Straight-line fetch after reset
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk); chk("seq_addr0", imem_addr, 32'h0); chk("seq_req0", 32'(imem_req), 32'd1);
      @(negedge clk); chk("seq_addr1", imem_addr, 32'h4); chk("seq_dec_valid1", 32'(dec_valid), 32'd0);
      @(negedge clk); chk("seq_addr2", imem_addr, 32'h8);
      chk("seq_dec_valid2", 32'(dec_valid), 32'd1); chk("seq_dec_pc2", dec_pc, 32'h0);
      @(negedge clk); chk("taken_addr", imem_addr, 32'h40);

      // Decode stall for five cycles
      @(posedge clk); #1 dec_ready = 1'b0;
      @(negedge clk); chk("stall_req0", 32'(imem_req), 32'd0);
      @(negedge clk);
      chk("stall_req1", 32'(imem_req), 32'd0);
      chk("stall_head_pc", dec_pc, 32'h8);
      chk("stall_head_taken", 32'(dec_pred_taken), 32'd1);
      chk("stall_head_pred_pc", dec_pred_pc, 32'h40);
      chk("stall_head_instr", dec_instr, rdata_of(32'h8));
      repeat (3) @(negedge clk);
      chk("stall_hold_pc", dec_pc, 32'h8); chk("stall_req_end", 32'(imem_req), 32'd0);
      @(posedge clk); #1 dec_ready = 1'b1;
      repeat (5) @(posedge clk);

      // Redirect while a response is outstanding
      #1 redirect_valid = 1'b1; redirect_pc = 32'h103;
      @(negedge clk); chk("redir_req_low", 32'(imem_req), 32'd0);
      @(posedge clk); #1 redirect_valid = 1'b0;
      @(negedge clk);
      chk("redir_flushed", 32'(dec_valid), 32'd0);
      chk("redir_addr", imem_addr, 32'h100);
      chk("redir_req", 32'(imem_req), 32'd1);
      repeat (4) @(posedge clk);

      // Back-to-back redirects, then grant withheld
      #1 redirect_valid = 1'b1; redirect_pc = 32'h203;
      @(posedge clk); #1 redirect_pc = 32'h20;
      @(posedge clk); #1 redirect_valid = 1'b0; imem_gnt = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("gnt_low_addr", imem_addr, 32'h20);
         chk("gnt_low_no_push", 32'(dec_valid), 32'd0);
      end
      @(posedge clk); #1 imem_gnt = 1'b1;
      @(negedge clk); chk("gnt_resume_addr", imem_addr, 32'h20);
      repeat (4) @(posedge clk);

      // Asynchronous reset with a response pending
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         @(posedge clk); #1;
         if (imem_rvalid === 1'b1) got = 1'b1;
      end
      chk("rvalid_pending", 32'(got), 32'd1);
      chk("pre_rst_dec_valid", 32'(dec_valid), 32'd1);
      #1 rst = 1'b1;
      #1;
      chk("async_rst_dec_valid", 32'(dec_valid), 32'd0);
      chk("async_rst_req", 32'(imem_req), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("post_rst_addr", imem_addr, 32'h0);
      chk("post_rst_dec_valid", 32'(dec_valid), 32'd0);
      repeat (6) @(posedge clk);

      // Drain everything still expected
      #1 imem_gnt = 1'b0;
      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
      @(negedge clk);
      chk("drain_empty", 32'(exp_q.size()), 32'd0);
      chk("drain_dec_valid", 32'(dec_valid), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
